// File: rtl/operand_issue.sv
// ---------------------------------------------------------------------------
// operand_issue
//   Operand read / issue stage for a single-issue RV32I integer pipe.
//   Decodes R-type and I-type ALU instructions, reads the 32x32 register file
//   (with write-back bypass), and presents a registered operand bundle to the
//   ALU behind a valid/ready handshake with one cycle of latency.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   upstream instruction valid
//   in_ready   out  1   stage can accept an instruction this cycle
//   in_instr   in  32   RV32I instruction word
//   wb_en      in   1   register write-back enable
//   wb_rd      in   5   write-back register index
//   wb_data    in  32   write-back value
//   out_valid  out  1   operand bundle valid
//   out_ready  in   1   ALU consumes the bundle
//   dataA      out 32   operand A
//   dataB      out 32   operand B
//   op         out  3   ALU operation (funct3)
//   func7      out  1   ALU modifier (SUB / SRA)
//   en         out  1   ALU enable (valid, legal bundle)
//   rd         out  5   destination register
//   illegal    out  1   bundle is not an ALU instruction
// ---------------------------------------------------------------------------
module operand_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic [2:0]  op,
    output logic        func7,
    output logic        en,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // -----------------------------------------------------------------------
    // Register file. x0 is never written, and its read is forced to zero too.
    // -----------------------------------------------------------------------
    logic [31:0] rf_q [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd_f;
    logic [2:0]  funct3;
    logic [31:0] imm_i;

    assign opcode = in_instr[6:0];
    assign rd_f   = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};

    // Operand read with bypass: a write-back landing on the same edge the
    // instruction is captured must be seen, since the array only updates at
    // that edge.
    function automatic logic [31:0] rd_port(input logic [4:0] idx,
                                            input logic       byp_en,
                                            input logic [4:0] byp_rd,
                                            input logic [31:0] byp_data,
                                            input logic [31:0] arr_val);
        if (idx == 5'd0)
            return 32'd0;
        else if (byp_en && (byp_rd == idx))
            return byp_data;
        else
            return arr_val;
    endfunction

    logic [31:0] rs1_val, rs2_val;

    assign rs1_val = rd_port(rs1, wb_en, wb_rd, wb_data, rf_q[rs1]);
    assign rs2_val = rd_port(rs2, wb_en, wb_rd, wb_data, rf_q[rs2]);

    // -----------------------------------------------------------------------
    // Decode into next-bundle values
    // -----------------------------------------------------------------------
    logic [31:0] dataA_d, dataB_d;
    logic [2:0]  op_d;
    logic        func7_d;
    logic        illegal_d;

    always_comb begin
        dataA_d   = 32'd0;
        dataB_d   = 32'd0;
        op_d      = 3'd0;
        func7_d   = 1'b0;
        illegal_d = 1'b1;
        case (opcode)
            OPC_R: begin
                dataA_d   = rs1_val;
                dataB_d   = rs2_val;
                op_d      = funct3;
                func7_d   = in_instr[30];
                illegal_d = 1'b0;
            end
            OPC_I: begin
                dataA_d   = rs1_val;
                dataB_d   = imm_i;
                op_d      = funct3;
                // Only SRAI/SRLI carry a modifier; for other I-types bit 30
                // is just immediate bits.
                func7_d   = (funct3 == 3'b101) ? in_instr[30] : 1'b0;
                illegal_d = 1'b0;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Handshake and output bundle
    // -----------------------------------------------------------------------
    logic        out_valid_q;
    logic [31:0] dataA_q, dataB_q;
    logic [2:0]  op_q;
    logic        func7_q;
    logic [4:0]  rd_q;
    logic        illegal_q;
    logic        accept;

    // Reset forces ready high; the accept term masks it so nothing loads.
    assign in_ready = rst || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dataA_q     <= 32'd0;
            dataB_q     <= 32'd0;
            op_q        <= 3'd0;
            func7_q     <= 1'b0;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            dataA_q     <= dataA_d;
            dataB_q     <= dataB_d;
            op_q        <= op_d;
            func7_q     <= func7_d;
            rd_q        <= rd_f;
            illegal_q   <= illegal_d;
        end else if (out_ready) begin
            // Consumed with nothing to replace it; bundle fields hold.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign dataA     = dataA_q;
    assign dataB     = dataB_q;
    assign op        = op_q;
    assign func7     = func7_q;
    assign rd        = rd_q;
    assign illegal   = illegal_q;
    assign en        = out_valid_q && !illegal_q;

endmodule
